calculadora_ctrl: RTL and testbench

- Keypad-driven sequencer for the 4-digit decimal calculator datapath (sumador / restador / multiplicador, 14-bit, max 9999).
- Accumulates operand A and operand B from decimal key presses and latches the operation.
- Presents A, B and the operation select to the ALU mux, then captures the result and flag.
- Converts each displayed value to 4-digit BCD with a sequential double-dabble and hands the BCD to the display driver.

---
 rtl/calculadora_ctrl.sv | 154 +++++++++++++++
 tb/tb_calculadora_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/calculadora_ctrl.sv
// Keypad sequencer for the 4-digit decimal calculator: builds operands A/B, drives the
// ALU mux, captures the result and converts every displayed value to BCD by double-dabble.
module calculadora_ctrl #(
  parameter int BITS        = 14,
  parameter int DIGITS      = 4,
  parameter int MAX_DECIMAL = 9999
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                KEY_VALID,
  input  logic [3:0]          KEY_CODE,
  output logic [BITS-1:0]     A_OUT,
  output logic [BITS-1:0]     B_OUT,
  output logic [1:0]          SEL,
  input  logic [BITS-1:0]     ALU_O,
  input  logic                ALU_FLAG,
  output logic [4*DIGITS-1:0] BCD,
  output logic                NEG,
  output logic                ERROR,
  output logic                BUSY,
  output logic                DISP_VALID
);
  localparam int BW = 4*DIGITS;
  localparam int SW = BW + BITS;
  localparam int CW = $clog2(BITS);
  localparam logic [BITS-1:0] DIG_LIMIT = BITS'((MAX_DECIMAL - 9) / 10);
  localparam logic [CW-1:0]   LAST      = CW'(BITS - 1);

  typedef enum logic [2:0] {ENTRY_A, ENTRY_B, EXEC, CONV, RESULT} state_t;
  typedef enum logic [2:0] {
    ACT_NONE, ACT_CLR, ACT_DIG, ACT_OP_A, ACT_OP_B, ACT_CHAIN, ACT_NEW_A, ACT_EXEC
  } act_t;

  state_t state, state_d, ret_state;
  act_t   act;

  logic [SW-1:0]   sr, sr_pre, sr_step;
  logic [CW-1:0]   cnt;
  logic [BITS-1:0] res_q, opnd, opnd_next, key_ext;
  logic            pend_neg, pend_err;
  logic            key_ok, is_dig, is_op, is_eq, is_clr;
  logic [3:0]      key_off;

  logic [DIGITS-1:0][3:0] dig_in, dig_adj;

  // Shift-add-3: bias every BCD digit >= 5 before the shift so it carries correctly.
  assign dig_in = sr[SW-1:BITS];
  for (genvar g = 0; g < DIGITS; g++) begin : g_dd
    assign dig_adj[g] = (dig_in[g] >= 4'd5) ? dig_in[g] + 4'd3 : dig_in[g];
  end
  assign sr_pre  = {dig_adj, sr[BITS-1:0]};
  assign sr_step = {sr_pre[SW-2:0], 1'b0};

  assign BUSY    = (state == EXEC) || (state == CONV);
  assign key_ok  = KEY_VALID && !BUSY && (KEY_CODE != 4'd15);
  assign is_dig  = KEY_CODE <= 4'd9;
  assign is_op   = (KEY_CODE >= 4'd10) && (KEY_CODE <= 4'd12);
  assign is_eq   = KEY_CODE == 4'd13;
  assign is_clr  = KEY_CODE == 4'd14;
  assign key_off = KEY_CODE - 4'd10;
  assign key_ext = {{(BITS-4){1'b0}}, KEY_CODE};
  assign opnd      = (state == ENTRY_B) ? B_OUT : A_OUT;
  assign opnd_next = (opnd << 3) + (opnd << 1) + key_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ENTRY_A;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    act     = ACT_NONE;
    unique case (state)
      ENTRY_A, ENTRY_B: if (key_ok) begin
        if (is_clr) begin
          act = ACT_CLR; state_d = ENTRY_A;
        end else if (is_dig && opnd <= DIG_LIMIT) begin
          act = ACT_DIG; state_d = CONV;
        end else if (is_op) begin
          act = (state == ENTRY_A) ? ACT_OP_A : ACT_OP_B; state_d = ENTRY_B;
        end else if (is_eq && state == ENTRY_B) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        act = ACT_EXEC; state_d = CONV;
      end
      CONV: if (cnt == LAST) state_d = ret_state;
      RESULT: if (key_ok) begin
        if (is_clr) begin
          act = ACT_CLR; state_d = ENTRY_A;
        end else if (is_dig) begin
          act = ACT_NEW_A; state_d = CONV;
        end else if (is_op && !NEG && !ERROR) begin
          act = ACT_CHAIN; state_d = ENTRY_B;
        end
      end
      default: state_d = ENTRY_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A_OUT <= '0; B_OUT <= '0; SEL <= 2'b00; BCD <= '0;
      NEG <= 1'b0; ERROR <= 1'b0; DISP_VALID <= 1'b0;
      sr <= '0; cnt <= '0; res_q <= '0; pend_neg <= 1'b0; pend_err <= 1'b0;
      ret_state <= ENTRY_A;
    end else begin
      DISP_VALID <= 1'b0;
      if (state == CONV) begin
        sr  <= sr_step;
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          BCD <= sr_step[SW-1:BITS]; NEG <= pend_neg; ERROR <= pend_err;
          DISP_VALID <= 1'b1;
        end
      end
      unique case (act)
        ACT_CLR: begin
          A_OUT <= '0; B_OUT <= '0; SEL <= 2'b00; BCD <= '0;
          NEG <= 1'b0; ERROR <= 1'b0; DISP_VALID <= 1'b1;
          sr <= '0; cnt <= '0; res_q <= '0; pend_neg <= 1'b0; pend_err <= 1'b0;
        end
        ACT_DIG: begin
          if (state == ENTRY_B) B_OUT <= opnd_next;
          else                  A_OUT <= opnd_next;
          sr <= {{BW{1'b0}}, opnd_next}; cnt <= '0;
          pend_neg <= 1'b0; pend_err <= 1'b0; ret_state <= state;
        end
        ACT_OP_A: begin
          SEL <= key_off[1:0]; B_OUT <= '0;
        end
        ACT_OP_B: SEL <= key_off[1:0];
        ACT_CHAIN: begin
          A_OUT <= res_q; B_OUT <= '0; SEL <= key_off[1:0];
        end
        ACT_NEW_A: begin
          A_OUT <= key_ext; B_OUT <= '0; NEG <= 1'b0; ERROR <= 1'b0;
          sr <= {{BW{1'b0}}, key_ext}; cnt <= '0;
          pend_neg <= 1'b0; pend_err <= 1'b0; ret_state <= ENTRY_A;
        end
        ACT_EXEC: begin
          // Resta reports sign on the flag; suma/mult report out-of-range.
          res_q <= ALU_O;
          sr <= {{BW{1'b0}}, ALU_O}; cnt <= '0;
          pend_neg <= (SEL == 2'b01) & ALU_FLAG;
          pend_err <= (SEL != 2'b01) & ALU_FLAG;
          ret_state <= RESULT;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_calculadora_ctrl.sv
// Directed bench for calculadora_ctrl: table of key presses with expected display
// state and DISP_VALID latency, plus hand sequences for busy-drop and async reset.
module tb_calculadora_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        KEY_VALID = 1'b0;
  logic [3:0]  KEY_CODE = 4'd0;
  logic [13:0] A_OUT, B_OUT, ALU_O;
  logic [1:0]  SEL;
  logic        ALU_FLAG = 1'b0;
  logic [15:0] BCD;
  logic        NEG, ERROR, BUSY, DISP_VALID;

  int n_chk = 0;
  int n_err = 0;

  calculadora_ctrl #(.BITS(14), .DIGITS(4), .MAX_DECIMAL(9999)) dut (
    .clk(clk), .rst_n(rst_n), .KEY_VALID(KEY_VALID), .KEY_CODE(KEY_CODE),
    .A_OUT(A_OUT), .B_OUT(B_OUT), .SEL(SEL), .ALU_O(ALU_O), .ALU_FLAG(ALU_FLAG),
    .BCD(BCD), .NEG(NEG), .ERROR(ERROR), .BUSY(BUSY), .DISP_VALID(DISP_VALID)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic [13:0] alu;
    logic        flag;
    int          lat;   // cycle of DISP_VALID after accept edge; 0 = none expected
    int          a, b, sel, bcd;
    logic        neg, err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [3:0] code, input logic [13:0] alu, input logic flag,
                     input int lat, input int a, input int b, input int sel, input int bcd,
                     input logic neg, input logic err);
    vec_t v;
    v.code = code; v.alu = alu; v.flag = flag; v.lat = lat;
    v.a = a; v.b = b; v.sel = sel; v.bcd = bcd; v.neg = neg; v.err = err;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] c);
    @(negedge clk); KEY_CODE = c; KEY_VALID = 1'b1;
    @(negedge clk); KEY_VALID = 1'b0;
  endtask

  // Called at the negedge of cycle 1; returns the DISP_VALID cycle or 0 if none in 30.
  task automatic wait_dv(output int lat);
    int n = 1;
    lat = 0;
    while (n <= 30) begin
      if (DISP_VALID) begin lat = n; break; end
      @(negedge clk); n++;
    end
  endtask

  initial begin
    int lat;
    string tag;
    ALU_O = '0;

    // key, alu, flag, lat, A, B, SEL, BCD, NEG, ERR
    add(4'd1, 0, 0, 15, 1, 0, 0, 'h0001, 0, 0);
    add(4'd2, 0, 0, 15, 12, 0, 0, 'h0012, 0, 0);
    add(4'd3, 0, 0, 15, 123, 0, 0, 'h0123, 0, 0);
    add(4'd4, 0, 0, 15, 1234, 0, 0, 'h1234, 0, 0);
    add(4'd5, 0, 0, 0, 1234, 0, 0, 'h1234, 0, 0);
    add(4'd14, 0, 0, 1, 0, 0, 0, 'h0000, 0, 0);
    add(4'd5, 0, 0, 15, 5, 0, 0, 'h0005, 0, 0);
    add(4'd0, 0, 0, 15, 50, 0, 0, 'h0050, 0, 0);
    add(4'd0, 0, 0, 15, 500, 0, 0, 'h0500, 0, 0);
    add(4'd0, 0, 0, 15, 5000, 0, 0, 'h5000, 0, 0);
    add(4'd10, 0, 0, 0, 5000, 0, 0, 'h5000, 0, 0);
    add(4'd5, 0, 0, 15, 5000, 5, 0, 'h0005, 0, 0);
    add(4'd0, 0, 0, 15, 5000, 50, 0, 'h0050, 0, 0);
    add(4'd0, 0, 0, 15, 5000, 500, 0, 'h0500, 0, 0);
    add(4'd0, 0, 0, 15, 5000, 5000, 0, 'h5000, 0, 0);
    add(4'd13, 9999, 1, 16, 5000, 5000, 0, 'h9999, 0, 1);
    add(4'd10, 9999, 1, 0, 5000, 5000, 0, 'h9999, 0, 1);
    add(4'd14, 0, 0, 1, 0, 0, 0, 'h0000, 0, 0);
    add(4'd2, 0, 0, 15, 2, 0, 0, 'h0002, 0, 0);
    add(4'd5, 0, 0, 15, 25, 0, 0, 'h0025, 0, 0);
    add(4'd11, 0, 0, 0, 25, 0, 1, 'h0025, 0, 0);
    add(4'd1, 0, 0, 15, 25, 1, 1, 'h0001, 0, 0);
    add(4'd0, 0, 0, 15, 25, 10, 1, 'h0010, 0, 0);
    add(4'd0, 0, 0, 15, 25, 100, 1, 'h0100, 0, 0);
    add(4'd13, 75, 1, 16, 25, 100, 1, 'h0075, 1, 0);
    add(4'd12, 75, 1, 0, 25, 100, 1, 'h0075, 1, 0);
    add(4'd14, 0, 0, 1, 0, 0, 0, 'h0000, 0, 0);
    add(4'd9, 0, 0, 15, 9, 0, 0, 'h0009, 0, 0);
    add(4'd9, 0, 0, 15, 99, 0, 0, 'h0099, 0, 0);
    add(4'd12, 0, 0, 0, 99, 0, 2, 'h0099, 0, 0);
    add(4'd9, 0, 0, 15, 99, 9, 2, 'h0009, 0, 0);
    add(4'd9, 0, 0, 15, 99, 99, 2, 'h0099, 0, 0);
    add(4'd13, 9801, 0, 16, 99, 99, 2, 'h9801, 0, 0);
    add(4'd10, 0, 0, 0, 9801, 0, 0, 'h9801, 0, 0);
    add(4'd1, 0, 0, 15, 9801, 1, 0, 'h0001, 0, 0);
    add(4'd13, 9802, 0, 16, 9801, 1, 0, 'h9802, 0, 0);
    add(4'd7, 0, 0, 15, 7, 0, 0, 'h0007, 0, 0);
    add(4'd15, 0, 0, 0, 7, 0, 0, 'h0007, 0, 0);
    add(4'd13, 0, 0, 0, 7, 0, 0, 'h0007, 0, 0);

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_outs", {A_OUT, B_OUT, SEL, BCD, NEG, ERROR, BUSY, DISP_VALID}, 0);

    foreach (vq[i]) begin
      ALU_O = vq[i].alu; ALU_FLAG = vq[i].flag;
      press(vq[i].code);
      wait_dv(lat);
      tag = $sformatf("v%0d", i);
      chk({tag, "_lat"}, lat, vq[i].lat);
      chk({tag, "_a"}, int'(A_OUT), vq[i].a);
      chk({tag, "_b"}, int'(B_OUT), vq[i].b);
      chk({tag, "_sel"}, int'(SEL), vq[i].sel);
      chk({tag, "_bcd"}, int'(BCD), vq[i].bcd);
      chk({tag, "_flags"}, int'({NEG, ERROR}), int'({vq[i].neg, vq[i].err}));
    end

    // Keys during CONV are dropped: A=7 -> press 3, pulse 7 and BORRAR while busy.
    press(4'd3);
    lat = 0;
    for (int n = 1; n <= 30; n++) begin
      if (DISP_VALID) begin lat = n; break; end
      if (n == 3) chk("busy_mid_conv", int'(BUSY), 1);
      KEY_VALID = (n == 3) || (n == 6);
      KEY_CODE  = (n == 6) ? 4'd14 : 4'd7;
      @(negedge clk);
      KEY_VALID = 1'b0;
    end
    chk("busy_drop_lat", lat, 15);
    chk("busy_drop_a", int'(A_OUT), 73);
    chk("busy_drop_bcd", int'(BCD), 'h0073);

    // Async reset mid-CONV
    press(4'd4);
    repeat (3) @(negedge clk);
    chk("conv_busy", int'(BUSY), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", int'(BUSY), 0);
    chk("async_rst_bcd", int'(BCD), 0);
    chk("async_rst_a", int'(A_OUT), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_idle", int'({BUSY, DISP_VALID, BCD}), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
